// File: rtl/bus_trace_checker.sv
// Bus trace checker: replays a stream of expected CPU bus/register vectors against a
// core under test, one vector per observed CPU cycle. It sources read data from the
// head vector and logs every mismatching cycle into a small error FIFO.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start, clear           start a run (IDLE only); synchronous flush back to IDLE
//   halt_on_err            stop at the first mismatching cycle
//   cmp_mask               per-field compare enable {regs, RW, SYNC, DB, AB}
//   exp_*                  expected-vector push handshake and payload
//   obs_*                  observed CPU cycle (obs_valid strobes once per cycle)
//   rd_data, rd_data_valid DB field of the head vector for CPU reads
//   cpu_rdy                high while running
//   err_*                  mismatch log pop handshake and entry
//   state                  IDLE=0, RUN=1, HALTED=2, DONE=3
//   cycle_count, mismatch_count, underrun, err_overflow, pass   status
module bus_trace_checker #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned NREG      = 5,
  parameter int unsigned EXP_DEPTH = 16,
  parameter int unsigned ERR_DEPTH = 8,
  parameter int unsigned CW        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       halt_on_err,
  input  logic [4+NREG-1:0]          cmp_mask,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [AW+DW+2+NREG*DW-1:0] exp_vec,
  input  logic                       exp_last,
  input  logic                       obs_valid,
  input  logic [AW-1:0]              obs_ab,
  input  logic [DW-1:0]              obs_db,
  input  logic                       obs_sync,
  input  logic                       obs_rw,
  input  logic [NREG*DW-1:0]         obs_regs,
  output logic [DW-1:0]              rd_data,
  output logic                       rd_data_valid,
  output logic                       cpu_rdy,
  output logic                       err_valid,
  input  logic                       err_ready,
  output logic [CW-1:0]              err_cycle,
  output logic [4+NREG-1:0]          err_mask,
  output logic [1:0]                 state,
  output logic [CW-1:0]              cycle_count,
  output logic [CW-1:0]              mismatch_count,
  output logic                       underrun,
  output logic                       err_overflow,
  output logic                       pass
);

  localparam int unsigned VW  = AW + DW + 2 + NREG * DW;
  localparam int unsigned MW  = 4 + NREG;
  localparam int unsigned EAW = $clog2(EXP_DEPTH);
  localparam int unsigned LAW = $clog2(ERR_DEPTH);
  localparam logic [EAW:0] EXP_PTR_ONE = 1;
  localparam logic [LAW:0] ERR_PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StHalted = 2'd2, StDone = 2'd3} state_e;

  state_e state_q, state_d;
  logic [EAW:0] exp_wptr_q, exp_wptr_d, exp_rptr_q, exp_rptr_d;
  logic [LAW:0] err_wptr_q, err_wptr_d, err_rptr_q, err_rptr_d;
  logic [CW-1:0] cycle_q, cycle_d, mism_q, mism_d;
  logic underrun_q, underrun_d, overflow_q, overflow_d;

  // Each entry carries the last flag above the vector payload.
  logic [VW:0]      exp_mem [EXP_DEPTH];
  logic [CW+MW-1:0] err_mem [ERR_DEPTH];

  logic exp_empty, exp_full, err_empty, err_full, exp_push, log_push;
  logic [VW:0]   exp_head;
  logic [VW-1:0] head_vec;
  logic [MW-1:0] mis;

  // The extra MSB on each pointer tells full from empty when the indices match.
  assign exp_empty = exp_wptr_q == exp_rptr_q;
  assign exp_full  = (exp_wptr_q[EAW] != exp_rptr_q[EAW]) &&
                     (exp_wptr_q[EAW-1:0] == exp_rptr_q[EAW-1:0]);
  assign err_empty = err_wptr_q == err_rptr_q;
  assign err_full  = (err_wptr_q[LAW] != err_rptr_q[LAW]) &&
                     (err_wptr_q[LAW-1:0] == err_rptr_q[LAW-1:0]);

  assign exp_push = exp_valid && !exp_full && !clear;
  assign exp_head = exp_mem[exp_rptr_q[EAW-1:0]];
  assign head_vec = exp_head[VW-1:0];

  // DB is only checked on expected writes; on reads the checker drives the bus itself.
  always_comb begin
    mis    = '0;
    mis[0] = cmp_mask[0] && (obs_ab != head_vec[AW-1:0]);
    mis[1] = cmp_mask[1] && !head_vec[AW+DW+1] && (obs_db != head_vec[AW+DW-1:AW]);
    mis[2] = cmp_mask[2] && (obs_sync != head_vec[AW+DW]);
    mis[3] = cmp_mask[3] && (obs_rw != head_vec[AW+DW+1]);
    for (int i = 0; i < NREG; i++) begin
      mis[4+i] = cmp_mask[4+i] &&
                 (obs_regs[i*DW +: DW] != head_vec[AW+DW+2+i*DW +: DW]);
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_wptr_d = exp_wptr_q;
    exp_rptr_d = exp_rptr_q;
    err_wptr_d = err_wptr_q;
    err_rptr_d = err_rptr_q;
    cycle_d    = cycle_q;
    mism_d     = mism_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    log_push   = 1'b0;
    if (clear) begin
      state_d    = StIdle;
      exp_wptr_d = '0;
      exp_rptr_d = '0;
      err_wptr_d = '0;
      err_rptr_d = '0;
      cycle_d    = '0;
      mism_d     = '0;
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (exp_push) exp_wptr_d = exp_wptr_q + EXP_PTR_ONE;
      if (!err_empty && err_ready) err_rptr_d = err_rptr_q + ERR_PTR_ONE;
      unique case (state_q)
        StIdle: if (start) state_d = StRun;
        StRun: begin
          if (obs_valid) begin
            if (cycle_q != '1) cycle_d = cycle_q + CNT_ONE;
            if (!exp_empty) begin
              exp_rptr_d = exp_rptr_q + EXP_PTR_ONE;
              if (|mis) begin
                if (mism_q != '1) mism_d = mism_q + CNT_ONE;
                if (err_full) begin
                  overflow_d = 1'b1;
                end else begin
                  log_push   = 1'b1;
                  err_wptr_d = err_wptr_q + ERR_PTR_ONE;
                end
              end
              if ((|mis) && halt_on_err) state_d = StHalted;
              else if (exp_head[VW])     state_d = StDone;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      exp_wptr_q <= '0;
      exp_rptr_q <= '0;
      err_wptr_q <= '0;
      err_rptr_q <= '0;
      cycle_q    <= '0;
      mism_q     <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_wptr_q <= exp_wptr_d;
      exp_rptr_q <= exp_rptr_d;
      err_wptr_q <= err_wptr_d;
      err_rptr_q <= err_rptr_d;
      cycle_q    <= cycle_d;
      mism_q     <= mism_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; empty FIFOs mask their contents on the outputs.
  always_ff @(posedge clk) begin
    if (exp_push) exp_mem[exp_wptr_q[EAW-1:0]] <= {exp_last, exp_vec};
    if (log_push) err_mem[err_wptr_q[LAW-1:0]] <= {cycle_q, mis};
  end

  logic [CW+MW-1:0] err_head;
  assign err_head = err_mem[err_rptr_q[LAW-1:0]];

  assign exp_ready      = !exp_full;
  assign rd_data_valid  = !exp_empty;
  assign rd_data        = exp_empty ? '0 : head_vec[AW+DW-1:AW];
  assign cpu_rdy        = state_q == StRun;
  assign err_valid      = !err_empty;
  assign err_cycle      = err_empty ? '0 : err_head[CW+MW-1:MW];
  assign err_mask       = err_empty ? '0 : err_head[MW-1:0];
  assign state          = state_q;
  assign cycle_count    = cycle_q;
  assign mismatch_count = mism_q;
  assign underrun       = underrun_q;
  assign err_overflow   = overflow_q;
  assign pass           = (state_q == StDone) && (mism_q == '0) && !underrun_q && !overflow_q;

endmodule

// File: tb/tb_bus_trace_checker.sv
// Directed bench for bus_trace_checker; a monitor checks mismatch-log pops against a
// queue of expected {cycle, mask} entries filled by the stimulus.
module tb_bus_trace_checker;

  logic        clk = 1'b0;
  logic        rst, start, clear, halt_on_err;
  logic [8:0]  cmp_mask;
  logic        exp_valid, exp_ready, exp_last;
  logic [65:0] exp_vec;
  logic        obs_valid, obs_sync, obs_rw;
  logic [15:0] obs_ab;
  logic [7:0]  obs_db;
  logic [39:0] obs_regs;
  logic [7:0]  rd_data;
  logic        rd_data_valid, cpu_rdy, err_valid, err_ready;
  logic [31:0] err_cycle, cycle_count, mismatch_count;
  logic [8:0]  err_mask;
  logic [1:0]  state;
  logic        underrun, err_overflow, pass;

  bus_trace_checker dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .halt_on_err(halt_on_err),
    .cmp_mask(cmp_mask), .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_vec(exp_vec),
    .exp_last(exp_last), .obs_valid(obs_valid), .obs_ab(obs_ab), .obs_db(obs_db),
    .obs_sync(obs_sync), .obs_rw(obs_rw), .obs_regs(obs_regs), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .cpu_rdy(cpu_rdy), .err_valid(err_valid),
    .err_ready(err_ready), .err_cycle(err_cycle), .err_mask(err_mask), .state(state),
    .cycle_count(cycle_count), .mismatch_count(mismatch_count), .underrun(underrun),
    .err_overflow(err_overflow), .pass(pass)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [40:0] exp_log [$];
  logic [40:0] ent;

  localparam logic [39:0] REGS = 40'h11_22_33_44_55;
  logic [15:0] v_ab [4] = '{16'h8000, 16'hC000, 16'h8002, 16'h8003};
  logic [7:0]  v_db [4] = '{8'hA9, 8'h42, 8'h10, 8'h20};
  logic        v_sy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        v_rw [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] ab, input logic [7:0] db, input logic sy,
                      input logic rw, input logic last);
    exp_vec   = {REGS, rw, sy, db, ab};
    exp_last  = last;
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    exp_last  = 1'b0;
  endtask

  task automatic obs(input logic [15:0] ab, input logic [7:0] db, input logic sy,
                     input logic rw);
    obs_ab    = ab;
    obs_db    = db;
    obs_sync  = sy;
    obs_rw    = rw;
    obs_regs  = REGS;
    obs_valid = 1'b1;
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load4();
    for (int i = 0; i < 4; i++) push(v_ab[i], v_db[i], v_sy[i], v_rw[i], i == 3);
  endtask

  // Log monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && err_valid && err_ready) begin
      if (exp_log.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL log_unexpected: got cycle %0d mask %0h, required no entry",
                 err_cycle, err_mask);
      end else begin
        ent = exp_log.pop_front();
        check("log_cycle", 64'(err_cycle), 64'(ent[40:9]));
        check("log_mask", 64'(err_mask), 64'(ent[8:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; clear = 1'b0; halt_on_err = 1'b0; cmp_mask = 9'h1FF;
    exp_valid = 1'b0; exp_last = 1'b0; exp_vec = '0; obs_valid = 1'b0; obs_ab = '0;
    obs_db = '0; obs_sync = 1'b0; obs_rw = 1'b0; obs_regs = '0; err_ready = 1'b1;
    #12;
    check("rst_state", state, 0);
    check("rst_exp_ready", exp_ready, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_data_valid, 0);
    check("rst_cpu_rdy", cpu_rdy, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_counts", {cycle_count, mismatch_count}, 0);
    check("rst_flags", {underrun, err_overflow, pass}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // All-matching run of four vectors.
    load4();
    check("t1_rd_valid", rd_data_valid, 1);
    check("t1_rd_data", rd_data, 8'hA9);
    pulse_start();
    check("t1_run", state, 1);
    check("t1_cpu_rdy", cpu_rdy, 1);
    for (int i = 0; i < 4; i++) obs(v_ab[i], v_db[i], v_sy[i], v_rw[i]);
    check("t1_state", state, 3);
    check("t1_cycles", cycle_count, 4);
    check("t1_mism", mismatch_count, 0);
    check("t1_pass", pass, 1);
    check("t1_cpu_rdy_off", cpu_rdy, 0);
    pulse_clear();
    check("t1_clear", state, 0);

    // AB mismatch on vector #2, run to end.
    load4();
    exp_log.push_back({32'd1, 9'h001});
    pulse_start();
    for (int i = 0; i < 4; i++) obs(i == 1 ? 16'hC001 : v_ab[i], v_db[i], v_sy[i], v_rw[i]);
    check("t2_state", state, 3);
    check("t2_cycles", cycle_count, 4);
    check("t2_mism", mismatch_count, 1);
    check("t2_pass", pass, 0);
    tick(); tick();
    pulse_clear();

    // Same mismatch with halt-on-error.
    halt_on_err = 1'b1;
    load4();
    exp_log.push_back({32'd1, 9'h001});
    pulse_start();
    obs(v_ab[0], v_db[0], v_sy[0], v_rw[0]);
    obs(16'hC001, v_db[1], v_sy[1], v_rw[1]);
    check("t3_halted", state, 2);
    check("t3_cpu_rdy", cpu_rdy, 0);
    obs(v_ab[2], v_db[2], v_sy[2], v_rw[2]);
    obs(v_ab[3], v_db[3], v_sy[3], v_rw[3]);
    check("t3_still_halted", state, 2);
    check("t3_cycles", cycle_count, 2);
    check("t3_mism", mismatch_count, 1);
    pulse_clear();
    check("t3_flushed", rd_data_valid, 0);
    halt_on_err = 1'b0;

    // Read vector sources DB without comparing it; write vector compares DB.
    push(16'h0200, 8'hA9, 1'b0, 1'b1, 1'b0);
    push(16'h0201, 8'h55, 1'b0, 1'b0, 1'b1);
    check("t4_rd_data", rd_data, 8'hA9);
    exp_log.push_back({32'd1, 9'h002});
    pulse_start();
    obs(16'h0200, 8'h00, 1'b0, 1'b1);
    check("t4_read_ok", mismatch_count, 0);
    check("t4_rd_data2", rd_data, 8'h55);
    obs(16'h0201, 8'h54, 1'b0, 1'b0);
    check("t4_mism", mismatch_count, 1);
    check("t4_state", state, 3);
    tick(); tick();
    pulse_clear();

    // Underrun on empty FIFO, then fill the FIFO to capacity.
    pulse_start();
    obs(16'h0000, 8'h00, 1'b0, 1'b1);
    check("t5_underrun", underrun, 1);
    check("t5_cycles", cycle_count, 1);
    check("t5_mism", mismatch_count, 0);
    for (int i = 0; i < 16; i++) begin
      push(16'(i), 8'(i), 1'b0, 1'b1, 1'b0);
      if (i == 14) check("t5_ready_15", exp_ready, 1);
    end
    check("t5_ready_full", exp_ready, 0);
    check("t5_head", rd_data, 8'h00);
    // Clear wins over a same-cycle push.
    exp_valid = 1'b1;
    pulse_clear();
    exp_valid = 1'b0;
    check("t5_clear_push", rd_data_valid, 0);
    check("t5_clear_flags", {underrun, state}, 0);

    // Log overflow: nine mismatches, log of eight never popped.
    err_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(16'h1000 + 16'(i), 8'h00, 1'b0, 1'b1, i == 8);
      if (i < 8) exp_log.push_back({32'(i), 9'h001});
    end
    pulse_start();
    for (int i = 0; i < 9; i++) obs(16'h1001 + 16'(i), 8'h00, 1'b0, 1'b1);
    check("t6_overflow", err_overflow, 1);
    check("t6_mism", mismatch_count, 9);
    check("t6_state", state, 3);
    check("t6_pass", pass, 0);
    err_ready = 1'b1;
    for (int i = 0; i < 20 && err_valid; i++) tick();
    check("t6_log_drained", exp_log.size(), 0);
    check("t6_log_empty", err_valid, 0);
    pulse_clear();
    check("t6_clear_state", state, 0);
    check("t6_clear_counts", {cycle_count, mismatch_count}, 0);
    check("t6_clear_flags", {underrun, err_overflow}, 0);

    // Asynchronous reset in the middle of a run.
    push(16'h3000, 8'h01, 1'b0, 1'b1, 1'b0);
    push(16'h3001, 8'h02, 1'b0, 1'b1, 1'b1);
    pulse_start();
    obs(16'h3000, 8'h01, 1'b0, 1'b1);
    check("t7_pre_cycles", cycle_count, 1);
    #2 rst = 1'b0;
    #1;
    check("t7_state", state, 0);
    check("t7_ready", exp_ready, 1);
    check("t7_fifo", {rd_data_valid, rd_data}, 0);
    check("t7_counts", {cycle_count, mismatch_count}, 0);
    check("t7_cpu_rdy", cpu_rdy, 0);
    tick();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_trace_checker.md
Name: bus_trace_checker

Overview:
- Synthesisable successor to the 6502 file-driven bench; replays a stream of expected bus/register vectors against a CPU core cycle by cycle.
- Buffers expected vectors, supplies read data to the CPU, compares observed bus and register values, and logs mismatches.
- Width, register count and buffer depths are parametrised; supports halt-on-error and run-to-end modes.
- Sits between a trace source (host or BRAM loader) and the CPU_6502 / NESE CPU under test; usable in simulation and on FPGA.

Parameters:
- AW, 16, address bus width
- DW, 8, data bus and architectural register width
- NREG, 5, number of compared registers (A, X, Y, S, P order)
- EXP_DEPTH, 16, expected-vector FIFO depth (power of two, ≥2)
- ERR_DEPTH, 8, mismatch-log FIFO depth (power of two, ≥2)
- CW, 32, cycle and mismatch counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; IDLE→RUN
- clear  in  1  synchronous flush to IDLE
- halt_on_err  in  1  1 = stop at first mismatch
- cmp_mask  in  4+NREG  per-field compare enable (bit0 AB, 1 DB, 2 SYNC, 3 RW, 4+i reg i)
- exp_valid / exp_ready  in/out  1/1  expected-vector handshake
- exp_vec  in  AW+DW+2+NREG*DW  {regs[NREG-1..0], RW, SYNC, DB, AB}, AB in LSBs
- exp_last  in  1  marks final vector
- obs_valid  in  1  one strobe per CPU cycle
- obs_ab  in  AW  observed address
- obs_db  in  DW  observed data (CPU write data)
- obs_sync, obs_rw  in  1/1  observed SYNC, RW (1 = read)
- obs_regs  in  NREG*DW  observed registers
- rd_data  out  DW  DB field of FIFO head, driven to CPU on reads
- rd_data_valid  out  1  FIFO not empty
- cpu_rdy  out  1  1 only in RUN
- err_valid / err_ready  out/in  1/1  mismatch-log pop handshake
- err_cycle  out  CW  cycle index of logged mismatch
- err_mask  out  4+NREG  mismatching fields of logged entry
- state  out  2  IDLE=0, RUN=1, HALTED=2, DONE=3
- cycle_count, mismatch_count  out  CW/CW  counters
- underrun, err_overflow  out  1/1  sticky flags
- pass  out  1  DONE && mismatch_count==0 && !underrun && !err_overflow

Behaviour:
- Reset (rst=0, async): state=IDLE, both FIFOs empty, counters 0, sticky flags 0. All outputs 0 except exp_ready=1; rd_data=0.
- exp_ready = !exp_full. A push when full is ignored. Push and pop in the same cycle are both allowed. Pop on empty sees empty; no bypass.
- State transitions:
  - IDLE: accepts pushes. start → RUN.
  - RUN: each obs_valid is one CPU cycle.
    - Head present: pop the head, compare, cycle_count++.
    - FIFO empty: set underrun, cycle_count++, no compare, no pop.
  - Comparison rules:
    - Field i mismatches iff cmp_mask[i] && observed != expected.
    - DB is compared only when expected RW=0; on reads the checker sources DB.
  - Any mismatch: mismatch_count++, push {cycle_count pre-increment, mask} to the log. Log full → drop the entry and set err_overflow.
  - RUN exit conditions:
    - Mismatch with halt_on_err=1 → HALTED.
    - Else, popped vector with exp_last=1 → DONE.
    - Mismatch with halt_on_err=1 on the last vector → HALTED.
  - HALTED / DONE: ignore obs_valid; only clear exits (→ IDLE).
- Latency: state, counters and log update on the clk edge that samples obs_valid; visible the next cycle. cpu_rdy drops that same next cycle.
- rd_data / rd_data_valid are combinational from the FIFO head.
- Counters saturate at all-ones; they never wrap.
- clear has priority over start and obs_valid. It flushes both FIFOs and zeroes counters and flags. A same-cycle exp_valid push is discarded.
- start outside IDLE is ignored.
- FIFO pointers wrap modulo depth. Full/empty are distinguished by an extra pointer bit.
- The log pops on err_valid && err_ready in any state.

Test Plan:
- Load 4 matching vectors (last on #4), start, drive 4 obs_valid with matching values → state=DONE, cycle_count=4, mismatch_count=0, pass=1.
- Vector #2 expects AB=0xC000; observe 0xC001 with halt_on_err=0 → log entry {cycle=1, mask=0x001}; run completes, mismatch_count=1, pass=0.
- Same stimulus with halt_on_err=1 → state=HALTED after cycle 1, cpu_rdy=0, further obs_valid ignored (cycle_count stays 2).
- Read vector RW=1, DB=0xA9, observe obs_db=0x00 → rd_data=0xA9 before the strobe, no DB mismatch. Write vector RW=0, DB=0x55, observe 0x54 → mask bit1 set.
- Start with empty FIFO and one obs_valid → underrun=1, cycle_count=1; then push EXP_DEPTH vectors → exp_ready=0 after the 16th.
- Force ERR_DEPTH+1 mismatches without popping the log → err_overflow=1 with 8 entries retained. Assert clear → IDLE, all counters/flags 0. Mid-run rst=0 → immediate IDLE, outputs at reset values.
